// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one uart_tx among byte requesters
module uart_tx_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int IDX_W         = 2,
   parameter int START_TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 reset_btn,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 tx_start,
   output logic [7:0]           tx_data,
   input  logic                 tx_busy,
   output logic [IDX_W-1:0]     grant_id,
   output logic                 active,
   output logic                 err_timeout
);
   localparam int CNT_W = $clog2(START_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, START, SEND} state_t;

   state_t             state, state_n;
   logic [IDX_W-1:0]   last, last_n;
   logic [IDX_W-1:0]   grant_n;
   logic [NUM_REQ-1:0] ready_n;
   logic               tx_start_n;
   logic [7:0]         data_n;
   logic               err_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic               found;
   logic [IDX_W-1:0]   sel;
   logic [IDX_W-1:0]   cand;

   // Search last+1, last+2, ... with wrap; first valid requester wins.
   always_comb begin
      found = 1'b0;
      sel   = last;
      cand  = last;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = IDX_W'((int'(last) + k) % NUM_REQ);
         if (!found && req_valid[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end
   end

   always_comb begin
      state_n    = state;
      last_n     = last;
      grant_n    = grant_id;
      data_n     = tx_data;
      ready_n    = '0;
      tx_start_n = 1'b0;
      err_n      = err_timeout;
      cnt_n      = cnt;
      unique case (state)
         IDLE: begin
            if (found) begin
               ready_n[sel] = 1'b1;
               data_n       = req_data[8*sel +: 8];
               grant_n      = sel;
               last_n       = sel;
               cnt_n        = '0;
               tx_start_n   = 1'b1;
               state_n      = START;
            end
         end
         START: begin
            // A busy already high on entry counts as the uart taking the byte.
            if (tx_busy) begin
               state_n = SEND;
            end else if (cnt == CNT_W'(START_TIMEOUT - 1)) begin
               err_n   = 1'b1;
               state_n = IDLE;
            end else begin
               cnt_n      = cnt + 1'b1;
               tx_start_n = 1'b1;
            end
         end
         SEND: begin
            if (!tx_busy) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset_btn) begin
      if (reset_btn) begin
         state       <= IDLE;
         last        <= IDX_W'(NUM_REQ - 1);
         grant_id    <= '0;
         tx_data     <= 8'h00;
         req_ready   <= '0;
         tx_start    <= 1'b0;
         err_timeout <= 1'b0;
         cnt         <= '0;
      end else begin
         state       <= state_n;
         last        <= last_n;
         grant_id    <= grant_n;
         tx_data     <= data_n;
         req_ready   <= ready_n;
         tx_start    <= tx_start_n;
         err_timeout <= err_n;
         cnt         <= cnt_n;
      end
   end

   assign active = (state != IDLE);

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares one uart_tx instance (9600 baud, 50 MHz clk) among NUM_REQ byte requesters.
- Accepts one byte per grant through a valid/ready handshake and drives uart_tx start/data.
- Holds start until busy is seen, then waits for busy to fall.
- Sits between board-level message sources (button, counter or status reporters) and the uart_tx instance inside the top level.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDX_W, 2, grant index width; must equal clog2(NUM_REQ).
- START_TIMEOUT, 16, max clk cycles start is held waiting for tx_busy=1 before abort.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset_btn  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester byte-valid; held until the matching ready.
- req_data  in  8*NUM_REQ  byte for requester i at bits [8i+7:8i].
- req_ready  out  NUM_REQ  one-hot, single-cycle accept pulse.
- tx_start  out  1  to uart_tx start.
- tx_data  out  8  to uart_tx data; stable from accept until return to IDLE.
- tx_busy  in  1  from uart_tx busy.
- grant_id  out  IDX_W  index of the requester currently being served.
- active  out  1  high in any state other than IDLE.
- err_timeout  out  1  sticky; set when START times out.

Behaviour:
- Reset (async, reset_btn=1) forces: state=IDLE, req_ready=0, tx_start=0, tx_data=8'h00, grant_id=0, active=0, err_timeout=0. Round-robin pointer last=NUM_REQ-1, so requester 0 has first priority.
- IDLE:
  - If req_valid==0, stay in IDLE.
  - Otherwise select the first set bit searching last+1, last+2, ... with wrap modulo NUM_REQ.
  - In the same cycle (registered outputs), assert req_ready[sel] for exactly one cycle, latch tx_data<=req_data[sel], grant_id<=sel, last<=sel.
  - Next state: START.
- START:
  - tx_start=1 is asserted starting in the first START cycle and a timeout counter starts.
  - If tx_busy=1 is sampled: tx_start<=0, go to SEND.
  - If the counter reaches START_TIMEOUT without tx_busy: tx_start<=0, err_timeout<=1, go to IDLE. The byte is dropped; the pointer still advances.
- SEND:
  - tx_start=0.
  - Wait for tx_busy=0, then go to IDLE.
  - One idle cycle is guaranteed between bytes, so IDLE re-arbitration happens no earlier than the cycle after busy falls.
- Latency: from req_valid rising in IDLE, ready pulses on the next edge and tx_start rises on the same edge.
- tx_busy already 1 on entry to START (tx busy left over): treated as acceptance. This is a legal corner; no fault is raised.
- Changes to req_valid or req_data while not in IDLE are ignored; only the latched byte is sent.
- Simultaneous requests are resolved strictly by round-robin; no requester is served twice while another valid requester is waiting.
- Dropping req_valid before ready is a protocol violation; the behaviour is simply that the request is not seen.
- Reset mid-frame (START or SEND) returns to IDLE immediately. The uart_tx shares reset_btn, so the line returns to idle too; the in-flight byte is lost.
- err_timeout is cleared only by reset.

Test Plan:
- Single request: req_valid=4'b0001, req_data[7:0]=8'h31 -> ready[0] one-cycle pulse, tx_start high until busy, tx line sends 0x31 (start bit, LSB first, 5208 clk/bit), active falls after busy falls.
- All four valid simultaneously with bytes 'A','B','C','D' after reset -> grant order 0,1,2,3; tx sends "ABCD"; each ready is exactly one pulse.
- Fairness: req0 held continuously valid while req2 asserts during req0's frame -> next grant is 2, then 0; req0 is never granted twice in a row.
- Timeout: tx_busy tied 0, req1 valid -> tx_start high for 16 cycles, then low; err_timeout=1; state returns to IDLE; grant pointer = 1.
- Reset mid-frame: assert reset_btn during the SEND data bits -> all outputs at reset values within the same cycle (async); after release, a new request to req3 is served first by req0-priority order.
- Data stability: change req_data[15:8] during SEND of req1 -> the transmitted byte equals the value latched at accept.
